dkong_obj_linebuf: RTL and testbench

Double-buffered object line buffer directly upstream of the colour-palette stage; produces the 6-bit object pixel stream (OBJ_D) that the palette mux merges with VRAM pixels.
- Sprite engine renders the next scanline into the write bank while the current scanline is read out of the read bank at the 6 MHz pixel rate.
- Each location is cleared as it is read.
- Object bits [1:0]==0 mean transparent, which the downstream mux relies on.

---
 rtl/dkong_obj_linebuf.sv | 162 ++++++++++++++++
 tb/tb_dkong_obj_linebuf.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dkong_obj_linebuf.sv
// Double-buffered object line buffer feeding the colour-palette stage.
//
// The sprite engine writes the next scanline into the write bank while the current scanline
// is read out of the read bank at the 6 MHz pixel rate. Every location is cleared as it is read.
// Object bits [1:0]==0 mean transparent. The first opaque pixel written to an x position wins,
// and later opaque writes to that position are dropped.
//
// Ports:
//   CLK_24M       system clock
//   W_1EF_RST     asynchronous active-low reset
//   CLK_6M_EN     pixel-rate enable, one CLK_24M cycle in four
//   I_LINE_START  swap banks (sampled on CLK_6M_EN)
//   I_WR_EN       object pixel write request (sampled on CLK_6M_EN)
//   I_WR_X        write x position
//   I_WR_D        write pixel {colour[3:0], pixel[1:0]}
//   I_RD_EN       active-display readout (sampled on CLK_6M_EN)
//   I_RD_X        horizontal pixel counter
//   I_FLIP        screen flip; the read address is ~I_RD_X when set
//   O_OBJ_D       object pixel to the palette stage, one pixel of latency
//   O_INIT_BUSY   high while the post-reset clear sweep runs
module dkong_obj_linebuf #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 6,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic              CLK_24M,
  input  logic              W_1EF_RST,
  input  logic              CLK_6M_EN,
  input  logic              I_LINE_START,
  input  logic              I_WR_EN,
  input  logic [ADDR_W-1:0] I_WR_X,
  input  logic [DATA_W-1:0] I_WR_D,
  input  logic              I_RD_EN,
  input  logic [ADDR_W-1:0] I_RD_X,
  input  logic              I_FLIP,
  output logic [DATA_W-1:0] O_OBJ_D,
  output logic              O_INIT_BUSY
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Control state
  logic              bank_q;
  logic              busy_q;
  logic [ADDR_W-1:0] sweep_q;

  // Write pipeline: p1 = read the old contents, p2 = conditional commit
  logic              wr_p1_q, wr_p2_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              wr_bank_q;

  // Read pipeline: p1 = read, p2 = capture value and clear the location
  logic              rd_p1_q, rd_p2_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_bank_q;
  logic [DATA_W-1:0] rd_val_q;
  logic [DATA_W-1:0] obj_q;

  // Per-bank single-port RAM interface
  logic [ADDR_W-1:0] bank_addr [2];
  logic              bank_we   [2];
  logic [DATA_W-1:0] bank_wd   [2];
  logic [DATA_W-1:0] bank_rd   [2];

  logic wr_commit;
  assign wr_commit = wr_p2_q && (bank_rd[wr_bank_q][1:0] == 2'b00);

  // Writes and reads always target opposite banks, so each bank needs only one port.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_addr[b] = '0;
      bank_we[b]   = 1'b0;
      bank_wd[b]   = '0;
      if (busy_q) begin
        bank_addr[b] = sweep_q;
        bank_we[b]   = 1'b1;
      end else if ((wr_p1_q || wr_p2_q) && (wr_bank_q == b[0])) begin
        bank_addr[b] = wr_addr_q;
        bank_we[b]   = wr_commit;
        bank_wd[b]   = wr_data_q;
      end else if ((rd_p1_q || rd_p2_q) && (rd_bank_q == b[0])) begin
        bank_addr[b] = rd_addr_q;
        bank_we[b]   = rd_p2_q;
      end
    end
  end

  // The RAM contents are not reset; the init sweep clears them instead.
  for (genvar g = 0; g < 2; g++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge CLK_24M) begin
      if (bank_we[g]) begin
        mem[bank_addr[g]] <= bank_wd[g];
      end
      rd_q <= mem[bank_addr[g]];
    end

    assign bank_rd[g] = rd_q;
  end

  always_ff @(posedge CLK_24M or negedge W_1EF_RST) begin
    if (!W_1EF_RST) begin
      bank_q    <= 1'b0;
      busy_q    <= INIT_CLEAR;
      sweep_q   <= '0;
      wr_p1_q   <= 1'b0;
      wr_p2_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_bank_q <= 1'b0;
      rd_p1_q   <= 1'b0;
      rd_p2_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_bank_q <= 1'b1;
      rd_val_q  <= '0;
      obj_q     <= '0;
    end else begin
      wr_p1_q <= 1'b0;
      wr_p2_q <= wr_p1_q;
      rd_p1_q <= 1'b0;
      rd_p2_q <= rd_p1_q;

      if (busy_q) begin
        sweep_q <= sweep_q + 1'b1;
        if (sweep_q == '1) begin
          busy_q <= 1'b0;
        end
      end else if (CLK_6M_EN) begin
        // Operations sampled on this enable use the old bank; the swap applies from the next.
        if (I_LINE_START) begin
          bank_q <= ~bank_q;
        end
        // Transparent requests never need to touch the RAM.
        if (I_WR_EN && (I_WR_D[1:0] != 2'b00)) begin
          wr_p1_q   <= 1'b1;
          wr_addr_q <= I_WR_X;
          wr_data_q <= I_WR_D;
          wr_bank_q <= bank_q;
        end
        if (I_RD_EN) begin
          rd_p1_q   <= 1'b1;
          rd_addr_q <= I_FLIP ? ~I_RD_X : I_RD_X;
        end
        rd_bank_q <= ~bank_q;
        // Present the previous pixel's value; the slot stays 0 unless a read fills it.
        obj_q    <= rd_val_q;
        rd_val_q <= '0;
      end

      if (rd_p2_q) begin
        rd_val_q <= bank_rd[rd_bank_q];
      end
    end
  end

  assign O_OBJ_D     = obj_q;
  assign O_INIT_BUSY = busy_q;

endmodule

// File: tb/tb_dkong_obj_linebuf.sv
module tb_dkong_obj_linebuf;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       ls;
  logic       we;
  logic [7:0] wx;
  logic [5:0] wd;
  logic       re;
  logic [7:0] rx;
  logic       fl;
  logic [5:0] obj;
  logic       busy;

  int total;
  int bad;

  // Behavioural model: two line arrays, a bank pointer, the value owed at the next enable,
  // and the number of clock edges the clear sweep still occupies.
  logic [5:0] mdl_mem [2][256];
  bit         mdl_bank;
  int         mdl_busy;
  logic [5:0] mdl_pend;
  logic [5:0] mdl_obj;

  dkong_obj_linebuf dut (
    .CLK_24M     (clk),
    .W_1EF_RST   (rst_n),
    .CLK_6M_EN   (en),
    .I_LINE_START(ls),
    .I_WR_EN     (we),
    .I_WR_X      (wx),
    .I_WR_D      (wd),
    .I_RD_EN     (re),
    .I_RD_X      (rx),
    .I_FLIP      (fl),
    .O_OBJ_D     (obj),
    .O_INIT_BUSY (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int x = 0; x < 256; x++) begin
        mdl_mem[b][x] = '0;
      end
    end
    mdl_bank = 1'b0;
    mdl_pend = '0;
    mdl_obj  = '0;
    mdl_busy = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mdl_busy > 0) mdl_busy--;
  endtask

  // One pixel slot: the enable cycle followed by three idle cycles.
  task automatic pixel(input bit p_ls, input bit p_we, input logic [7:0] p_wx,
                       input logic [5:0] p_wd, input bit p_re, input logic [7:0] p_rx,
                       input bit p_fl);
    logic [7:0] a;
    ls = p_ls;
    we = p_we;
    wx = p_wx;
    wd = p_wd;
    re = p_re;
    rx = p_rx;
    fl = p_fl;
    en = 1'b1;
    if (mdl_busy == 0) begin
      mdl_obj = mdl_pend;
      if (p_re) begin
        a = p_fl ? ~p_rx : p_rx;
        mdl_pend = mdl_mem[~mdl_bank][a];
        mdl_mem[~mdl_bank][a] = '0;
      end else begin
        mdl_pend = '0;
      end
      if (p_we && (p_wd[1:0] != 2'b00) && (mdl_mem[mdl_bank][p_wx][1:0] == 2'b00)) begin
        mdl_mem[mdl_bank][p_wx] = p_wd;
      end
      if (p_ls) mdl_bank = ~mdl_bank;
    end
    tick();
    en = 1'b0;
    ls = 1'b0;
    we = 1'b0;
    re = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic idle();
    pixel(1'b0, 1'b0, 8'h00, 6'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0; ls = 1'b0; we = 1'b0; re = 1'b0; fl = 1'b0;
    wx = '0; wd = '0; rx = '0;
    model_reset();
    tick();
    tick();
    total++;
    if (obj !== 6'h00) begin
      bad++;
      $display("FAIL reset_obj: got %h expected %h", obj, 6'h00);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_busy: got %b expected %b", busy, 1'b1);
    end
    rst_n = 1'b1;
    mdl_busy = 256;
  endtask

  task automatic test_init_sweep();
    int busy_ticks;
    busy_ticks = 0;
    for (int i = 1; i <= 260; i++) begin
      tick();
      if (busy === 1'b1) busy_ticks++;
      total++;
      if (busy !== (mdl_busy > 0)) begin
        bad++;
        $display("FAIL sweep_busy tick %0d: got %b expected %b", i, busy, mdl_busy > 0);
      end
    end
    total++;
    if (busy_ticks != 255) begin
      bad++;
      $display("FAIL sweep_len: got %0d expected %0d busy samples", busy_ticks, 255);
    end
    // Both banks must read back as all zero.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 256; i++) begin
        pixel(i == 255, 1'b0, 8'h00, 6'h00, 1'b1, 8'(i), 1'b0);
        total++;
        if (obj !== 6'h00) begin
          bad++;
          $display("FAIL sweep_clear bank pass %0d x %0d: got %h expected %h",
                   pass, i, obj, 6'h00);
        end
      end
    end
    idle();
    total++;
    if (obj !== 6'h00) begin
      bad++;
      $display("FAIL sweep_clear last: got %h expected %h", obj, 6'h00);
    end
  endtask

  task automatic test_basic();
    pixel(1'b0, 1'b1, 8'h10, 6'h2D, 1'b0, 8'h00, 1'b0);
    pixel(1'b1, 1'b0, 8'h00, 6'h00, 1'b0, 8'h00, 1'b0);
    pixel(1'b0, 1'b0, 8'h00, 6'h00, 1'b1, 8'h10, 1'b0);
    total++;
    if (obj !== 6'h00) begin
      bad++;
      $display("FAIL basic_latency: got %h expected %h", obj, 6'h00);
    end
    idle();
    total++;
    if (obj !== 6'h2D) begin
      bad++;
      $display("FAIL basic_read: got %h expected %h", obj, 6'h2D);
    end
    idle();
    total++;
    if (obj !== 6'h00) begin
      bad++;
      $display("FAIL basic_no_read: got %h expected %h", obj, 6'h00);
    end
    pixel(1'b1, 1'b0, 8'h00, 6'h00, 1'b0, 8'h00, 1'b0);
    pixel(1'b1, 1'b0, 8'h00, 6'h00, 1'b0, 8'h00, 1'b0);
    pixel(1'b0, 1'b0, 8'h00, 6'h00, 1'b1, 8'h10, 1'b0);
    idle();
    total++;
    if (obj !== 6'h00) begin
      bad++;
      $display("FAIL basic_cleared: got %h expected %h", obj, 6'h00);
    end
  endtask

  task automatic test_priority();
    pixel(1'b0, 1'b1, 8'h20, 6'h15, 1'b0, 8'h00, 1'b0);
    pixel(1'b0, 1'b1, 8'h20, 6'h3E, 1'b0, 8'h00, 1'b0);
    pixel(1'b0, 1'b1, 8'h20, 6'h0C, 1'b0, 8'h00, 1'b0);
    pixel(1'b1, 1'b1, 8'h21, 6'h0C, 1'b0, 8'h00, 1'b0);
    pixel(1'b0, 1'b0, 8'h00, 6'h00, 1'b1, 8'h20, 1'b0);
    pixel(1'b0, 1'b0, 8'h00, 6'h00, 1'b1, 8'h21, 1'b0);
    total++;
    if (obj !== 6'h15) begin
      bad++;
      $display("FAIL prio_first_wins: got %h expected %h", obj, 6'h15);
    end
    idle();
    total++;
    if (obj !== 6'h00) begin
      bad++;
      $display("FAIL prio_transparent_drop: got %h expected %h", obj, 6'h00);
    end
  endtask

  task automatic test_flip_wrap();
    pixel(1'b0, 1'b1, 8'h05, 6'h09, 1'b0, 8'h00, 1'b1);
    pixel(1'b1, 1'b1, 8'hFF, 6'h22, 1'b0, 8'h00, 1'b1);
    pixel(1'b0, 1'b0, 8'h00, 6'h00, 1'b1, 8'hFA, 1'b1);
    pixel(1'b0, 1'b0, 8'h00, 6'h00, 1'b1, 8'h00, 1'b1);
    total++;
    if (obj !== 6'h09) begin
      bad++;
      $display("FAIL flip_read: got %h expected %h", obj, 6'h09);
    end
    idle();
    total++;
    if (obj !== 6'h22) begin
      bad++;
      $display("FAIL flip_wrap_ff: got %h expected %h", obj, 6'h22);
    end
  endtask

  task automatic test_same_enable_swap();
    pixel(1'b1, 1'b1, 8'h40, 6'h11, 1'b0, 8'h00, 1'b0);
    pixel(1'b0, 1'b0, 8'h00, 6'h00, 1'b1, 8'h40, 1'b0);
    idle();
    total++;
    if (obj !== 6'h11) begin
      bad++;
      $display("FAIL swap_old_bank: got %h expected %h", obj, 6'h11);
    end
  endtask

  task automatic test_reset_midline();
    pixel(1'b0, 1'b1, 8'h30, 6'h2D, 1'b0, 8'h00, 1'b0);
    pixel(1'b1, 1'b0, 8'h00, 6'h00, 1'b0, 8'h00, 1'b0);
    pixel(1'b0, 1'b0, 8'h00, 6'h00, 1'b1, 8'h30, 1'b0);
    idle();
    total++;
    if (obj !== 6'h2D) begin
      bad++;
      $display("FAIL midrst_setup: got %h expected %h", obj, 6'h2D);
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (obj !== 6'h00) begin
      bad++;
      $display("FAIL midrst_async_obj: got %h expected %h", obj, 6'h00);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_busy: got %b expected %b", busy, 1'b1);
    end
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    mdl_busy = 256;
    // Writes, reads and swaps during the sweep must all be ignored.
    for (int i = 0; i < 64; i++) begin
      pixel(1'($urandom_range(0, 1)), 1'b1, 8'h50, 6'h3F, 1'b1, 8'h30, 1'b0);
      total++;
      if (obj !== 6'h00) begin
        bad++;
        $display("FAIL midrst_sweep_obj %0d: got %h expected %h", i, obj, 6'h00);
      end
      total++;
      if (busy !== (mdl_busy > 0)) begin
        bad++;
        $display("FAIL midrst_sweep_busy %0d: got %b expected %b", i, busy, mdl_busy > 0);
      end
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_sweep_end: got %b expected %b", busy, 1'b0);
    end
    pixel(1'b1, 1'b0, 8'h00, 6'h00, 1'b1, 8'h50, 1'b0);
    pixel(1'b0, 1'b0, 8'h00, 6'h00, 1'b1, 8'h50, 1'b0);
    total++;
    if (obj !== 6'h00) begin
      bad++;
      $display("FAIL midrst_write_ignored_a: got %h expected %h", obj, 6'h00);
    end
    idle();
    total++;
    if (obj !== 6'h00) begin
      bad++;
      $display("FAIL midrst_write_ignored_b: got %h expected %h", obj, 6'h00);
    end
    pixel(1'b1, 1'b1, 8'h50, 6'h3F, 1'b0, 8'h00, 1'b0);
    pixel(1'b0, 1'b0, 8'h00, 6'h00, 1'b1, 8'h50, 1'b0);
    idle();
    total++;
    if (obj !== 6'h3F) begin
      bad++;
      $display("FAIL midrst_after_sweep: got %h expected %h", obj, 6'h3F);
    end
  endtask

  task automatic test_random();
    logic [7:0] r_wx;
    logic [7:0] r_rx;
    for (int i = 0; i < 400; i++) begin
      r_wx = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      r_rx = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) r_rx = ~r_rx;
      pixel($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, r_wx, 6'($urandom),
            $urandom_range(0, 3) != 0, r_rx, 1'($urandom_range(0, 1)));
      total++;
      if (obj !== mdl_obj) begin
        bad++;
        $display("FAIL random_obj %0d: got %h expected %h", i, obj, mdl_obj);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_init_sweep();
    test_basic();
    test_priority();
    test_flip_wrap();
    test_same_enable_swap();
    test_reset_midline();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
